// File: rtl/to8bit_serializer.sv
// to8bit_serializer: splits an 8/16/32-bit word into a registered byte stream.
// Valid/ready input handshake; the next word can load on the same edge that
// retires the last byte of the current one, so back-to-back words have no gap.
module to8bit_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [31:0] dataIn,
    input  logic [1:0]  dataS,
    input  logic        inValid,
    output logic        inReady,
    output logic [7:0]  dataOut,
    output logic        outValid,
    output logic        outLast,
    output logic        err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic        err_q, err_d;

    logic        accept;
    logic [31:0] aligned;

    assign inReady  = enb && (state_q == IDLE || (state_q == SEND && cnt_q == 2'd0));
    assign accept   = inValid && inReady;
    assign dataOut  = dout_q;
    assign outValid = vld_q;
    assign outLast  = last_q;
    assign err      = err_q;

    // Left-justify the used bytes so MSB-first emission always reads [31:24].
    always_comb begin
        aligned = dataIn;
        case (dataS)
            2'b00:   aligned = {dataIn[7:0], 24'h0};
            2'b01:   aligned = {dataIn[15:0], 16'h0};
            default: aligned = dataIn;
        endcase
    end

    // Next-state: load on accept, shift while bytes remain, else drop to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        last_d  = last_q;
        err_d   = err_q;
        if (enb) begin
            err_d = 1'b0;
            if (accept) begin
                if (dataS == 2'b11) begin
                    // Reserved width: drop the word, flag it, leave dataOut as is.
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = (dataS == 2'b00) ? 2'd0 : (dataS == 2'b01) ? 2'd1 : 2'd3;
                    vld_d   = 1'b1;
                    last_d  = (dataS == 2'b00);
                    state_d = SEND;
                    if (MSB_FIRST) begin
                        dout_d = aligned[31:24];
                        sh_d   = {aligned[23:0], 8'h0};
                    end else begin
                        dout_d = dataIn[7:0];
                        sh_d   = {8'h0, dataIn[31:8]};
                    end
                end
            end else if (state_q == SEND && cnt_q != 2'd0) begin
                cnt_d  = cnt_q - 2'd1;
                last_d = (cnt_q == 2'd1);
                vld_d  = 1'b1;
                if (MSB_FIRST) begin
                    dout_d = sh_q[31:24];
                    sh_d   = {sh_q[23:0], 8'h0};
                end else begin
                    dout_d = sh_q[7:0];
                    sh_d   = {8'h0, sh_q[31:8]};
                end
            end else begin
                // Last byte retired with no follow-on word: dataOut keeps its value.
                state_d = IDLE;
                vld_d   = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    // State and output registers; async active-low reset discards any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            sh_q    <= 32'h0;
            dout_q  <= 8'h00;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_to8bit_serializer.sv
// Bench for to8bit_serializer: MSB-first and LSB-first instances share the
// stimulus; each is compared every cycle against a byte-queue reference model.
module tb_to8bit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic [31:0] dataIn;
    logic [1:0]  dataS;
    logic        inValid;

    logic        rdy_m, rdy_l;
    logic [7:0]  dout_m, dout_l;
    logic        vld_m, vld_l;
    logic        last_m, last_l;
    logic        err_m, err_l;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes still to be shown, plus the currently shown outputs.
    logic [7:0] pend_m[$];
    logic [7:0] pend_l[$];
    logic [7:0] e_dout_m, e_dout_l;
    logic       e_vld, e_last, e_err;

    always #5 clk = ~clk;

    to8bit_serializer #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .enb(enb), .dataIn(dataIn), .dataS(dataS),
        .inValid(inValid), .inReady(rdy_m), .dataOut(dout_m),
        .outValid(vld_m), .outLast(last_m), .err(err_m)
    );

    to8bit_serializer #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .enb(enb), .dataIn(dataIn), .dataS(dataS),
        .inValid(inValid), .inReady(rdy_l), .dataOut(dout_l),
        .outValid(vld_l), .outLast(last_l), .err(err_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return enb && (pend_m.size() == 0);
    endfunction

    task automatic model_reset();
        pend_m.delete();
        pend_l.delete();
        e_dout_m = 8'h00;
        e_dout_l = 8'h00;
        e_vld = 1'b0;
        e_last = 1'b0;
        e_err = 1'b0;
    endtask

    // One rising edge of the reference model, using the inputs held across it.
    task automatic model_edge();
        int n;
        if (!enb) return;
        e_err = 1'b0;
        if (inValid && model_ready()) begin
            if (dataS == 2'b11) begin
                e_err = 1'b1;
                e_vld = 1'b0;
                e_last = 1'b0;
                return;
            end
            n = (dataS == 2'b00) ? 1 : (dataS == 2'b01) ? 2 : 4;
            for (int k = 0; k < n; k++) begin
                pend_m.push_back(dataIn[8*(n-1-k) +: 8]);
                pend_l.push_back(dataIn[8*k +: 8]);
            end
        end
        if (pend_m.size() > 0) begin
            e_dout_m = pend_m.pop_front();
            e_dout_l = pend_l.pop_front();
            e_vld = 1'b1;
            e_last = (pend_m.size() == 0);
        end else begin
            e_vld = 1'b0;
            e_last = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("dataOut_msb", dout_m, e_dout_m);
        chk("dataOut_lsb", dout_l, e_dout_l);
        chk("outValid_msb", vld_m, e_vld);
        chk("outValid_lsb", vld_l, e_vld);
        chk("outLast_msb", last_m, e_last);
        chk("outLast_lsb", last_l, e_last);
        chk("err_msb", err_m, e_err);
        chk("err_lsb", err_l, e_err);
    endtask

    // Inputs are already set; check inReady, take one edge, check registered outputs.
    task automatic step();
        #1;
        chk("inReady_msb", rdy_m, model_ready());
        chk("inReady_lsb", rdy_l, model_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("inReady_after_rst", rdy_m, enb);
        #2;
        rst = 1'b1;
    endtask

    task automatic put(input logic [1:0] s, input logic [31:0] d);
        dataS = s;
        dataIn = d;
        inValid = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        enb = 1'b1;
        dataIn = 32'h0;
        dataS = 2'b00;
        inValid = 1'b0;
        model_reset();
        #12;
        check_outputs();
        rst = 1'b1;

        // Single 8-bit word.
        put(2'b00, 32'h000000d4);
        step();
        chk("s2_byte", dout_m, 32'hd4);
        chk("s2_last", last_m, 32'h1);
        inValid = 1'b0;
        step();
        chk("s2_idle", vld_m, 32'h0);
        step();

        // 16-bit word: e4 then 57 (MSB first), 57 then e4 (LSB first).
        put(2'b01, 32'h0000e457);
        step();
        chk("s3_first_msb", dout_m, 32'he4);
        chk("s3_first_lsb", dout_l, 32'h57);
        inValid = 1'b0;
        step();
        chk("s3_second_msb", dout_m, 32'h57);
        chk("s3_second_lsb", dout_l, 32'he4);
        step();

        // Back-to-back 32-bit then 8-bit word with inValid held.
        put(2'b10, 32'hd476d6e4);
        step();
        dataS = 2'b00;
        dataIn = 32'h00000076;
        repeat (4) step();
        chk("s4_second_word", dout_m, 32'h76);
        inValid = 1'b0;
        repeat (2) step();

        // enb low for three cycles while the second byte is shown.
        put(2'b10, 32'hd476d6e4);
        step();
        inValid = 1'b0;
        step();
        enb = 1'b0;
        repeat (3) step();
        chk("s5_hold", dout_m, 32'h76);
        enb = 1'b1;
        repeat (4) step();

        // Reserved width.
        put(2'b11, 32'hdeadbeef);
        step();
        chk("s6_err", err_m, 32'h1);
        inValid = 1'b0;
        repeat (2) step();

        // Reset in the middle of a word.
        put(2'b10, 32'h11223344);
        step();
        inValid = 1'b0;
        step();
        do_reset();
        repeat (2) step();

        // Randomized traffic with enable gaps and occasional resets.
        for (int i = 0; i < 600; i++) begin
            enb = ($urandom_range(0, 9) != 0);
            inValid = ($urandom_range(0, 3) != 0);
            dataS = 2'($urandom_range(0, 3));
            dataIn = $urandom;
            if ($urandom_range(0, 79) == 0) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
